// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
//   Shared definitions for the M-stage memory access unit:
//     - access size encodings (byte/half/word; 2'b11 behaves as word)
//     - exception codes reported on exc_code
//     - FSM state enumeration
//     - helper functions: misalignment test, byte-enable generation,
//       store-lane replication and load extension
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] EXC_NONE        = 2'b00;
   localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_ST_MISALIGN = 2'b10;
   localparam logic [1:0] EXC_RANGE       = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_DRAIN = 2'b01,
      S_READ  = 2'b10
   } mau_state_e;

   // Half needs addr[0]==0; word (10 or 11) needs addr[1:0]==0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (size == SZ_HALF) begin
         bad = addr_lo[0];
      end else if (size[1]) begin
         bad = (addr_lo != 2'b00);
      end
      return bad;
   endfunction

   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr_lo;
         SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Right-justified store data copied onto every lane it could occupy;
   // the byte enables then select the lane(s) actually written.
   function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] rep;
      case (size)
         SZ_BYTE: rep = {4{wdata[7:0]}};
         SZ_HALF: rep = {2{wdata[15:0]}};
         default: rep = wdata;
      endcase
      return rep;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  addr_lo,
                                            input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
         SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Circular FIFO of posted stores {word index, byte enables, lane data} with a
//   parallel comparator that reports whether any valid entry targets a given
//   word index (byte enables are deliberately ignored for that match).
//   Enqueue and dequeue may happen in the same cycle at any occupancy,
//   including full.
// Ports
//   clk, reset      clock, synchronous active-low reset (clears all entries)
//   enq_i/..._i     push request and entry fields
//   deq_i           pop head entry (ignored when empty)
//   head_*_o        head entry fields (valid when !empty_o)
//   match_idx_i     word index to compare, match_o = any valid entry hits
//   count_o         number of valid entries; full_o / empty_o flags
// -----------------------------------------------------------------------------
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 12
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enq_i,
   input  logic [IDX_W-1:0]               enq_idx_i,
   input  logic [3:0]                     enq_be_i,
   input  logic [31:0]                    enq_data_i,
   input  logic                           deq_i,
   output logic [IDX_W-1:0]               head_idx_o,
   output logic [3:0]                     head_be_o,
   output logic [31:0]                    head_data_o,
   input  logic [IDX_W-1:0]               match_idx_i,
   output logic                           match_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           full_o,
   output logic                           empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] match_vec;

   logic [IDX_W-1:0] idx_q  [DEPTH];
   logic [3:0]       be_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];

   logic do_enq;
   logic do_deq;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign do_deq = deq_i & ~empty_o;
   // When full, a push is only possible because the head leaves this cycle.
   assign do_enq = enq_i & (~full_o | do_deq);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (do_deq) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      // Applied after the dequeue so a full-buffer push into the slot being
      // vacated leaves that slot valid.
      if (do_enq) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      case ({do_enq, do_deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Entry payload needs no reset: the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         idx_q[tail_q]  <= enq_idx_i;
         be_q[tail_q]   <= enq_be_i;
         data_q[tail_q] <= enq_data_i;
      end
   end

   assign head_idx_o  = idx_q[head_q];
   assign head_be_o   = be_q[head_q];
   assign head_data_o = data_q[head_q];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign match_vec[gi] = valid_q[gi] & (idx_q[gi] == match_idx_i);
      end
   endgenerate

   assign match_o = |match_vec;

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   M-stage data-memory access unit. Accepts one load/store per valid/ready
//   handshake, checks alignment then range, posts stores into a store buffer
//   that drains into a byte-masked RAM, and reads the RAM with a configurable
//   latency. Loads that hit a buffered word wait until it has drained.
// Ports
//   clk, reset              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake (accept = valid & ready)
//   req_we, req_size,       store flag, access size, load sign extension,
//   req_signed, req_addr,   byte address, right-justified store data,
//   req_wdata, req_pc       PC of the instruction (for exception report)
//   resp_valid, resp_rdata  completion pulse and extended load data
//   exc_valid, exc_code,    fault pulse, cause, PC and address of the
//   exc_pc, exc_addr        faulting request
//   sb_count, sb_empty      store-buffer occupancy
// -----------------------------------------------------------------------------
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RD_LATENCY = 2,
   parameter int          WB_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_we,
   input  logic [1:0]                      req_size,
   input  logic                            req_signed,
   input  logic [31:0]                     req_addr,
   input  logic [31:0]                     req_wdata,
   input  logic [31:0]                     req_pc,
   output logic                            resp_valid,
   output logic [31:0]                     resp_rdata,
   output logic                            exc_valid,
   output logic [1:0]                      exc_code,
   output logic [31:0]                     exc_pc,
   output logic [31:0]                     exc_addr,
   output logic [$clog2(WB_DEPTH+1)-1:0]   sb_count,
   output logic                            sb_empty
);

   localparam int CNT_W    = $clog2(WB_DEPTH+1);
   localparam int LAT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
   // S_READ lasts RD_LATENCY-1 cycles; this is the counter value of its last one.
   localparam int LAT_LAST = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;

   // ---------------------------------------------------------------- state
   mau_state_e             state_q;
   logic                   run_q;
   logic [LAT_W-1:0]       lat_cnt_q;
   logic                   resp_valid_q;
   logic                   resp_load_q;
   logic                   exc_valid_q;
   logic [1:0]             exc_code_q;
   logic [31:0]            exc_pc_q;
   logic [31:0]            exc_addr_q;
   logic [ADDR_WIDTH-1:0]  ld_idx_q;
   logic [1:0]             ld_size_q;
   logic [1:0]             ld_off_q;
   logic                   ld_signed_q;

   logic [31:0]            mem_q [0:(2**ADDR_WIDTH)-1];
   logic [31:0]            ram_rd_q;

   // ---------------------------------------------------------------- decode
   logic [31:0]            off_w;
   logic [ADDR_WIDTH-1:0]  req_idx;
   logic                   misal;
   logic                   oor;
   logic                   accept;
   logic                   fault;
   logic                   st_acc;
   logic                   ld_acc;

   logic                   sb_full;
   logic                   sb_deq;
   logic                   sb_match;
   logic [ADDR_WIDTH-1:0]  match_idx;
   logic [ADDR_WIDTH-1:0]  sb_head_idx;
   logic [3:0]             sb_head_be;
   logic [31:0]            sb_head_data;
   logic [CNT_W-1:0]       sb_count_w;

   logic                   rd_issue;
   logic [ADDR_WIDTH-1:0]  rd_idx;

   assign off_w   = req_addr - BASE_ADDR;
   assign req_idx = off_w[ADDR_WIDTH+1:2];
   assign misal   = is_misaligned(req_size, req_addr[1:0]);
   // Any offset bit above the RAM span means out of range (the unsigned
   // subtraction also wraps addresses below BASE_ADDR into this case).
   assign oor     = ((off_w >> (ADDR_WIDTH + 2)) != 32'd0);

   // reset is folded in so ready is low for the whole time reset is held.
   assign req_ready = reset & run_q & (state_q == S_IDLE) & ~(req_we & sb_full);
   assign accept    = req_valid & req_ready;
   assign fault     = accept & (misal | oor);
   assign st_acc    = accept & ~fault & req_we;
   assign ld_acc    = accept & ~fault & ~req_we;

   // An accepted store takes priority over draining, so a burst of stores
   // accumulates in the buffer and drains in the following idle cycles.
   assign sb_deq    = reset & ~sb_empty & ~st_acc;

   // In S_IDLE the incoming load is checked; afterwards the held load is.
   assign match_idx = (state_q == S_IDLE) ? req_idx : ld_idx_q;
   assign rd_idx    = match_idx;
   assign rd_issue  = ((state_q == S_IDLE)  & ld_acc & ~sb_match) |
                      ((state_q == S_DRAIN) & ~sb_match);

   store_buffer #(
      .DEPTH (WB_DEPTH),
      .IDX_W (ADDR_WIDTH)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .enq_i       (st_acc),
      .enq_idx_i   (req_idx),
      .enq_be_i    (be_gen(req_size, req_addr[1:0])),
      .enq_data_i  (lane_rep(req_size, req_wdata)),
      .deq_i       (sb_deq),
      .head_idx_o  (sb_head_idx),
      .head_be_o   (sb_head_be),
      .head_data_o (sb_head_data),
      .match_idx_i (match_idx),
      .match_o     (sb_match),
      .count_o     (sb_count_w),
      .full_o      (sb_full),
      .empty_o     (sb_empty)
   );

   assign sb_count = sb_count_w;

   // ---------------------------------------------------------------- RAM
   // Simple dual-port: byte-masked write from the buffer head, registered read.
   always_ff @(posedge clk) begin
      if (sb_deq) begin
         for (int b = 0; b < 4; b++) begin
            if (sb_head_be[b]) begin
               mem_q[sb_head_idx][8*b +: 8] <= sb_head_data[8*b +: 8];
            end
         end
      end
   end

   // The RAM output register holds the word until the response; no store can
   // be accepted meanwhile and the word is not buffered, so it stays current.
   always_ff @(posedge clk) begin
      if (rd_issue) begin
         ram_rd_q <= mem_q[rd_idx];
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         run_q        <= 1'b0;
         lat_cnt_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_load_q  <= 1'b0;
         exc_valid_q  <= 1'b0;
         exc_code_q   <= EXC_NONE;
         exc_pc_q     <= 32'd0;
         exc_addr_q   <= 32'd0;
         ld_idx_q     <= '0;
         ld_size_q    <= SZ_BYTE;
         ld_off_q     <= 2'b00;
         ld_signed_q  <= 1'b0;
      end else begin
         run_q        <= 1'b1;
         resp_valid_q <= 1'b0;
         exc_valid_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fault) begin
                  exc_valid_q <= 1'b1;
                  exc_code_q  <= misal ? (req_we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN)
                                       : EXC_RANGE;
                  exc_pc_q    <= req_pc;
                  exc_addr_q  <= req_addr;
               end else if (st_acc) begin
                  resp_valid_q <= 1'b1;
                  resp_load_q  <= 1'b0;
               end else if (ld_acc) begin
                  ld_idx_q    <= req_idx;
                  ld_size_q   <= req_size;
                  ld_off_q    <= req_addr[1:0];
                  ld_signed_q <= req_signed;
                  if (sb_match) begin
                     state_q <= S_DRAIN;
                  end else if (RD_LATENCY == 1) begin
                     resp_valid_q <= 1'b1;
                     resp_load_q  <= 1'b1;
                  end else begin
                     state_q   <= S_READ;
                     lat_cnt_q <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (!sb_match) begin
                  if (RD_LATENCY == 1) begin
                     resp_valid_q <= 1'b1;
                     resp_load_q  <= 1'b1;
                     state_q      <= S_IDLE;
                  end else begin
                     state_q   <= S_READ;
                     lat_cnt_q <= '0;
                  end
               end
            end
            S_READ: begin
               if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
                  resp_valid_q <= 1'b1;
                  resp_load_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  lat_cnt_q <= lat_cnt_q + LAT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign resp_valid = resp_valid_q;
   // Extension is applied on the RAM output register; stores and idle cycles
   // present zero.
   assign resp_rdata = (resp_valid_q & resp_load_q)
                       ? load_ext(ram_rd_q, ld_size_q, ld_off_q, ld_signed_q)
                       : 32'd0;
   assign exc_valid  = exc_valid_q;
   assign exc_code   = exc_code_q;
   assign exc_pc     = exc_pc_q;
   assign exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed and randomized checks of mem_access_unit against a byte-level
//   memory model: reset state, store/load data and extension, store-buffer
//   hazard latency, buffer-full back-pressure, exceptions, reset abort.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int          AW     = 12;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          RD_LAT = 2;
   localparam int          WBD    = 4;
   localparam int          CW     = $clog2(WBD+1);

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [31:0]   req_pc;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          exc_valid;
   logic [1:0]    exc_code;
   logic [31:0]   exc_pc;
   logic [31:0]   exc_addr;
   logic [CW-1:0] sb_count;
   logic          sb_empty;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE),
      .RD_LATENCY (RD_LAT),
      .WB_DEPTH   (WBD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .exc_valid  (exc_valid),
      .exc_code   (exc_code),
      .exc_pc     (exc_pc),
      .exc_addr   (exc_addr),
      .sb_count   (sb_count),
      .sb_empty   (sb_empty)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] pc_ctr   = 32'h0000_1000;
   logic [31:0] last_pc;
   logic [31:0] ref_mem [0:(1<<AW)-1];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // Model: a store replaces n bytes starting at the byte offset.
   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      int          off;
      off = int'(a[1:0]);
      w   = ref_mem[widx(a)];
      for (int k = 0; k < nbytes(sz); k++) w[8*(off+k) +: 8] = d[8*k +: 8];
      ref_mem[widx(a)] = w;
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] v;
      int          n;
      int          off;
      n   = nbytes(sz);
      off = int'(a[1:0]);
      w   = ref_mem[widx(a)];
      v   = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   // Presents a request, waits (bounded) for ready, leaves the bench in T+1.
   task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
      int waited;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      req_pc     = pc_ctr;
      last_pc    = pc_ctr;
      pc_ctr     = pc_ctr + 32'd4;
      waited     = 0;
      while (!req_ready && waited < 100) begin
         step();
         waited++;
      end
      check("req_ready_wait", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      send(1'b1, sz, 1'b0, a, d);
      check("st_resp_valid", resp_valid, 1'b1);
      check("st_resp_rdata", resp_rdata, 32'd0);
      model_store(sz, a, d);
      $display("store sz=%0d addr=%h data=%h", sz, a, d);
   endtask

   // exp_lat = 0 means latency is not checked.
   task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] a, input int exp_lat);
      logic [31:0] exp_v;
      int          lat;
      exp_v = model_load(sz, sg, a);
      send(1'b0, sz, sg, a, 32'd0);
      lat = 1;
      while (!resp_valid && lat < 60) begin
         step();
         lat++;
      end
      check("ld_resp_valid", resp_valid, 1'b1);
      check("ld_rdata", resp_rdata, exp_v);
      if (exp_lat > 0) check("ld_latency", lat, exp_lat);
      $display("load sz=%0d sg=%0d addr=%h rdata=%h exp=%h lat=%0d", sz, sg, a, resp_rdata, exp_v, lat);
   endtask

   task automatic do_fault(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [1:0] code);
      send(we, sz, 1'b0, a, 32'hDEAD_BEEF);
      check("exc_valid", exc_valid, 1'b1);
      check("exc_code", exc_code, code);
      check("exc_addr", exc_addr, a);
      check("exc_pc", exc_pc, last_pc);
      check("exc_no_resp", resp_valid, 1'b0);
      $display("fault we=%0d addr=%h code=%0d", we, a, exc_code);
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (!sb_empty && n < 50) begin
         step();
         n++;
      end
      check("sb_drained", sb_empty, 1'b1);
   endtask

   initial begin
      int          exp_cnt;
      int          i;
      int          guard;
      logic [1:0]  sz;
      logic [31:0] a;

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_pc     = 32'd0;
      for (int k = 0; k < (1<<AW); k++) ref_mem[k] = 32'd0;

      // ---- reset state
      step();
      step();
      check("rst_ready", req_ready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_exc_valid", exc_valid, 1'b0);
      check("rst_exc_code", exc_code, 2'd0);
      check("rst_exc_pc", exc_pc, 32'd0);
      check("rst_exc_addr", exc_addr, 32'd0);
      check("rst_sb_count", sb_count, 0);
      check("rst_sb_empty", sb_empty, 1'b1);
      reset = 1'b1;
      step();
      check("ready_after_reset", req_ready, 1'b1);

      // ---- 1: store then dependent byte load (hazard, one drain cycle)
      do_store(2'd2, 32'h10, 32'h1234_5678);
      do_load(2'd0, 1'b1, 32'h13, 1 + RD_LAT);
      check("t1_value", resp_rdata, 32'h0000_0012);

      // ---- 2: half store, signed / unsigned half loads, clean latency
      do_store(2'd1, 32'h22, 32'h0000_8001);
      wait_empty();
      do_load(2'd1, 1'b1, 32'h22, RD_LAT);
      check("t2_lh", resp_rdata, 32'hFFFF_8001);
      do_load(2'd1, 1'b0, 32'h22, RD_LAT);
      check("t2_lhu", resp_rdata, 32'h0000_8001);

      // ---- 3: WBD+1 back-to-back stores; ready drops only when full
      wait_empty();
      exp_cnt = 0;
      i       = 0;
      guard   = 0;
      while (i < WBD + 1 && guard < 40) begin
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_size   = 2'd2;
         req_signed = 1'b0;
         req_addr   = 32'h40 + 32'(4 * i);
         req_wdata  = $urandom;
         req_pc     = pc_ctr;
         check("t3_sb_count", sb_count, exp_cnt);
         check("t3_ready", req_ready, (exp_cnt != WBD));
         $display("burst i=%0d count=%0d ready=%0d", i, sb_count, req_ready);
         if (req_ready) begin
            model_store(2'd2, req_addr, req_wdata);
            step();
            exp_cnt++;
            i++;
         end else begin
            step();
            exp_cnt--;
         end
         guard++;
      end
      req_valid = 1'b0;
      check("t3_all_sent", i, WBD + 1);
      wait_empty();
      for (int k = 0; k < WBD + 1; k++) do_load(2'd2, 1'b0, 32'h40 + 32'(4 * k), RD_LAT);

      // ---- 4: exceptions and their priority; RAM untouched
      do_store(2'd2, 32'h0, 32'hCAFE_F00D);
      do_fault(1'b0, 2'd2, 32'h06, 2'b01);
      do_fault(1'b1, 2'd2, 32'(4 << AW), 2'b11);
      do_fault(1'b1, 2'd1, 32'h21, 2'b10);
      do_fault(1'b0, 2'd2, 32'(4 << AW) + 32'd2, 2'b01);
      wait_empty();
      do_load(2'd2, 1'b0, 32'h0, RD_LAT);
      check("t4_ram_kept", resp_rdata, 32'hCAFE_F00D);

      // ---- 5: reset during a read with entries buffered
      wait_empty();
      do_store(2'd2, 32'h800, 32'h1111_1111);
      do_store(2'd2, 32'h804, 32'h2222_2222);
      do_store(2'd2, 32'h808, 32'h3333_3333);
      send(1'b0, 2'd2, 1'b0, 32'h900, 32'd0);
      check("t5_count_before", sb_count, 2);
      reset = 1'b0;
      step();
      check("t5_no_resp", resp_valid, 1'b0);
      check("t5_sb_count", sb_count, 0);
      check("t5_sb_empty", sb_empty, 1'b1);
      check("t5_ready_in_rst", req_ready, 1'b0);
      step();
      reset = 1'b1;
      step();
      check("t5_ready_after", req_ready, 1'b1);
      for (int k = 0; k < 4; k++) begin
         check("t5_quiet", resp_valid, 1'b0);
         step();
      end

      // ---- 6: randomized traffic over 16 words
      for (int k = 0; k < 16; k++) do_store(2'd2, 32'h400 + 32'(4 * k), $urandom);
      for (int n = 0; n < 60; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'h400 + 32'(4 * $urandom_range(0, 15));
         if (sz == 2'd0)      a = a + 32'($urandom_range(0, 3));
         else if (sz == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            do_store(sz, a, $urandom);
         end else begin
            do_load(sz, 1'($urandom_range(0, 1)), a, sb_empty ? RD_LAT : 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
